// File: rtl/mem_pkg.sv
// Shared memory-port definitions: function codes, access-type codes and an
// index-width helper used by the arbiter and its testbench.
package mem_pkg;

    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    localparam logic [2:0] MT_X  = 3'd0;
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd4;
    localparam logic [2:0] MT_HU = 3'd5;

    // A single requester still needs a one-bit index.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each outstanding request.
// Push when full and pop when empty are ignored.
module tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Tag storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-requester arbiter onto one shared memory port; responses are routed back
// to the issuing port through an in-order tag FIFO.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int DEPTH  = 4,
    parameter int RR     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NPORTS-1:0]         req_valid,
    output logic [NPORTS-1:0]         req_ready,
    input  logic [NPORTS*AW-1:0]      req_addr,
    input  logic [NPORTS*DW-1:0]      req_data,
    input  logic [NPORTS-1:0]         req_fcn,
    input  logic [NPORTS*3-1:0]       req_typ,
    output logic [NPORTS-1:0]         resp_valid,
    output logic [DW-1:0]             resp_data,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [AW-1:0]             mem_req_addr,
    output logic [DW-1:0]             mem_req_data,
    output logic                      mem_req_fcn,
    output logic [2:0]                mem_req_typ,
    input  logic                      mem_resp_valid,
    input  logic [DW-1:0]             mem_resp_data,
    output logic [$clog2(DEPTH):0]    outstanding,
    output logic                      err_orphan
);

    localparam int IW = idx_w(NPORTS);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant;
    logic [IW-1:0] head_tag;
    logic          found;
    logic          full;
    logic          empty;
    logic          xfer;
    logic          pop;

    always_comb begin
        logic [IW-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            idx = (RR != 0) ? IW'((int'(rr_ptr) + i) % NPORTS) : IW'(i);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    // Issue is held off during reset and whenever the tag FIFO is full.
    assign mem_req_valid = found && !full && !reset;
    assign xfer          = mem_req_valid && mem_req_ready;
    assign req_ready     = xfer ? (NPORTS'(1) << grant) : '0;
    assign mem_req_addr  = req_addr[grant*AW +: AW];
    assign mem_req_data  = req_data[grant*DW +: DW];
    assign mem_req_fcn   = req_fcn[grant];
    assign mem_req_typ   = req_typ[grant*3 +: 3];

    assign pop        = mem_resp_valid && !empty;
    assign resp_valid = pop ? (NPORTS'(1) << head_tag) : '0;
    assign resp_data  = mem_resp_data;

    tag_fifo #(
        .WIDTH (IW),
        .DEPTH (DEPTH)
    ) u_tags (
        .clk   (clk),
        .reset (reset),
        .push  (xfer),
        .din   (grant),
        .pop   (pop),
        .dout  (head_tag),
        .full  (full),
        .empty (empty),
        .count (outstanding)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (xfer && (RR != 0))
                rr_ptr <= (grant == IW'(NPORTS-1)) ? '0 : grant + 1'b1;
            if (mem_resp_valid && empty)
                err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a 2-port round-robin instance (a_*) and a 3-port
// fixed-priority instance (b_*) sharing clock and reset.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Round-robin instance
    logic [1:0]  a_req_valid, a_req_ready, a_req_fcn, a_resp_valid;
    logic [63:0] a_req_addr, a_req_data;
    logic [5:0]  a_req_typ;
    logic [31:0] a_resp_data, a_mem_req_addr, a_mem_req_data, a_mem_resp_data;
    logic        a_mem_req_valid, a_mem_req_ready, a_mem_req_fcn, a_mem_resp_valid, a_err_orphan;
    logic [2:0]  a_mem_req_typ, a_outstanding;

    // Fixed-priority instance
    logic [2:0]  b_req_valid, b_req_ready, b_req_fcn, b_resp_valid;
    logic [95:0] b_req_addr, b_req_data;
    logic [8:0]  b_req_typ;
    logic [31:0] b_resp_data, b_mem_req_addr, b_mem_req_data, b_mem_resp_data;
    logic        b_mem_req_valid, b_mem_req_ready, b_mem_req_fcn, b_mem_resp_valid, b_err_orphan;
    logic [2:0]  b_mem_req_typ, b_outstanding;

    mem_port_arbiter #(.NPORTS(2), .AW(32), .DW(32), .DEPTH(4), .RR(1)) u_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_addr(a_req_addr), .req_data(a_req_data),
        .req_fcn(a_req_fcn), .req_typ(a_req_typ),
        .resp_valid(a_resp_valid), .resp_data(a_resp_data),
        .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready),
        .mem_req_addr(a_mem_req_addr), .mem_req_data(a_mem_req_data),
        .mem_req_fcn(a_mem_req_fcn), .mem_req_typ(a_mem_req_typ),
        .mem_resp_valid(a_mem_resp_valid), .mem_resp_data(a_mem_resp_data),
        .outstanding(a_outstanding), .err_orphan(a_err_orphan)
    );

    mem_port_arbiter #(.NPORTS(3), .AW(32), .DW(32), .DEPTH(4), .RR(0)) u_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(b_req_addr), .req_data(b_req_data),
        .req_fcn(b_req_fcn), .req_typ(b_req_typ),
        .resp_valid(b_resp_valid), .resp_data(b_resp_data),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready),
        .mem_req_addr(b_mem_req_addr), .mem_req_data(b_mem_req_data),
        .mem_req_fcn(b_mem_req_fcn), .mem_req_typ(b_mem_req_typ),
        .mem_resp_valid(b_mem_resp_valid), .mem_resp_data(b_mem_resp_data),
        .outstanding(b_outstanding), .err_orphan(b_err_orphan)
    );

    typedef struct {
        logic [2:0]  rv;
        logic        exp_valid;
        logic [2:0]  exp_ready;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        a_req_valid = 2'b00; a_mem_req_ready = 1'b0; a_mem_resp_valid = 1'b0; a_mem_resp_data = '0;
        a_req_addr = {32'h0000_0200, 32'h0000_0100};
        a_req_data = {32'hBBBB_0001, 32'hAAAA_0000};
        a_req_fcn  = {M_XRD, M_XWR};
        a_req_typ  = {MT_B, MT_W};
        b_req_valid = 3'b000; b_mem_req_ready = 1'b0; b_mem_resp_valid = 1'b0; b_mem_resp_data = '0;
        b_req_addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        b_req_data = '0;
        b_req_fcn  = '0;
        b_req_typ  = {MT_HU, MT_H, MT_W};

        vecs[0] = '{3'b000, 1'b0, 3'b000, 32'h0};
        vecs[1] = '{3'b001, 1'b1, 3'b001, 32'h100};
        vecs[2] = '{3'b010, 1'b1, 3'b010, 32'h200};
        vecs[3] = '{3'b100, 1'b1, 3'b100, 32'h300};
        vecs[4] = '{3'b101, 1'b1, 3'b001, 32'h100};
        vecs[5] = '{3'b110, 1'b1, 3'b010, 32'h200};
        vecs[6] = '{3'b111, 1'b1, 3'b001, 32'h100};
        vecs[7] = '{3'b011, 1'b1, 3'b001, 32'h100};

        // Reset state, with requests and a response already presented
        @(negedge clk);
        a_req_valid = 2'b11; a_mem_req_ready = 1'b1; a_mem_resp_valid = 1'b1;
        #1;
        check("rst_outstanding", 64'(a_outstanding), 64'd0);
        check("rst_mem_req_valid", 64'(a_mem_req_valid), 64'd0);
        check("rst_resp_valid", 64'(a_resp_valid), 64'd0);
        check("rst_err_orphan", 64'(a_err_orphan), 64'd0);
        check("rst_req_ready", 64'(a_req_ready), 64'd0);
        a_req_valid = 2'b00; a_mem_req_ready = 1'b0; a_mem_resp_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Fixed-priority grant table; ready pulses never span an edge
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b_req_valid = vecs[i].rv; b_mem_req_ready = 1'b0;
            #1;
            check($sformatf("fp_valid[%0d]", i), 64'(b_mem_req_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("fp_addr[%0d]", i), 64'(b_mem_req_addr), 64'(vecs[i].exp_addr));
            b_mem_req_ready = 1'b1;
            #1;
            check($sformatf("fp_ready[%0d]", i), 64'(b_req_ready), 64'(vecs[i].exp_ready));
            b_mem_req_ready = 1'b0;
        end

        // Fixed priority, ports 0 and 2 requesting with real transfers
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b_req_valid = (k < 3) ? 3'b101 : 3'b100;
            b_mem_req_ready = 1'b1;
            b_mem_resp_valid = (k >= 1);
            #1;
            check($sformatf("fp_seq_ready[%0d]", k), 64'(b_req_ready), (k < 3) ? 64'b001 : 64'b100);
            if (k >= 1)
                check($sformatf("fp_seq_resp[%0d]", k), 64'(b_resp_valid), 64'b001);
        end
        @(negedge clk);
        b_req_valid = 3'b000; b_mem_req_ready = 1'b0; b_mem_resp_valid = 1'b0;
        #1;
        check("fp_seq_outstanding", 64'(b_outstanding), 64'd1);

        // Round-robin alternation; memory answers two cycles after issue
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            a_req_valid = (k < 8) ? 2'b11 : 2'b00;
            a_mem_req_ready = 1'b1;
            a_mem_resp_valid = (k >= 2);
            a_mem_resp_data = 32'(k + 16);
            #1;
            check($sformatf("rr_outstanding[%0d]", k), 64'(a_outstanding), (k <= 8) ? 64'((k < 2) ? k : 2) : 64'd1);
            if (k < 8) begin
                check($sformatf("rr_grant[%0d]", k), 64'(a_req_ready), 64'(2'b01 << (k % 2)));
                check($sformatf("rr_addr[%0d]", k), 64'(a_mem_req_addr), (k % 2 == 0) ? 64'h100 : 64'h200);
            end
            if (k >= 2) begin
                check($sformatf("rr_resp[%0d]", k), 64'(a_resp_valid), 64'(2'b01 << ((k - 2) % 2)));
                check($sformatf("rr_resp_data[%0d]", k), 64'(a_resp_data), 64'(k + 16));
            end
        end
        @(negedge clk);
        a_mem_resp_valid = 1'b0; a_mem_req_ready = 1'b0;
        #1;
        check("rr_drained", 64'(a_outstanding), 64'd0);
        check("rr_no_orphan", 64'(a_err_orphan), 64'd0);

        // Fill to DEPTH with no responses; a pop does not bypass into issue
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a_req_valid = 2'b01; a_mem_req_ready = 1'b1;
            #1;
            check($sformatf("full_valid[%0d]", k), 64'(a_mem_req_valid), (k < 4) ? 64'd1 : 64'd0);
        end
        check("full_outstanding", 64'(a_outstanding), 64'd4);
        a_mem_resp_valid = 1'b1;
        #1;
        check("full_pop_resp", 64'(a_resp_valid), 64'b01);
        check("full_no_bypass", 64'(a_mem_req_valid), 64'd0);
        @(negedge clk);
        a_mem_resp_valid = 1'b0;
        #1;
        check("full_recover_cnt", 64'(a_outstanding), 64'd3);
        check("full_recover_valid", 64'(a_mem_req_valid), 64'd1);
        check("full_recover_ready", 64'(a_req_ready), 64'b01);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_req_valid = 2'b00; a_mem_resp_valid = 1'b1;
        end
        @(negedge clk);
        a_mem_resp_valid = 1'b0; a_mem_req_ready = 1'b0;
        #1;
        check("full_drained", 64'(a_outstanding), 64'd0);

        // Stall: grant and fields hold on port 0 while memory is not ready
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_req_valid = 2'b11; a_mem_req_ready = 1'b0;
            #1;
            check($sformatf("stall_valid[%0d]", k), 64'(a_mem_req_valid), 64'd1);
            check($sformatf("stall_ready[%0d]", k), 64'(a_req_ready), 64'b00);
            check($sformatf("stall_addr[%0d]", k), 64'(a_mem_req_addr), 64'h100);
            check($sformatf("stall_data[%0d]", k), 64'(a_mem_req_data), 64'hAAAA_0000);
            check($sformatf("stall_fcn_typ[%0d]", k), 64'({a_mem_req_fcn, a_mem_req_typ}), 64'({M_XWR, MT_W}));
        end
        @(negedge clk);
        a_mem_req_ready = 1'b1;
        #1;
        check("stall_release", 64'(a_req_ready), 64'b01);
        @(negedge clk);
        #1;
        check("stall_next_grant", 64'(a_req_ready), 64'b10);
        check("stall_next_typ", 64'(a_mem_req_typ), 64'(MT_B));
        @(negedge clk);
        a_req_valid = 2'b00; a_mem_req_ready = 1'b0;
        #1;
        check("pre_async_outstanding", 64'(a_outstanding), 64'd2);

        // Asynchronous reset between edges discards tags at once
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_outstanding", 64'(a_outstanding), 64'd0);
        check("async_mem_req_valid", 64'(a_mem_req_valid), 64'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        a_mem_resp_valid = 1'b1;
        #1;
        check("late_resp_valid", 64'(a_resp_valid), 64'b00);
        @(negedge clk);
        a_mem_resp_valid = 1'b0;
        #1;
        check("late_orphan", 64'(a_err_orphan), 64'd1);
        repeat (2) @(negedge clk);
        #1;
        check("orphan_sticky", 64'(a_err_orphan), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("orphan_reset", 64'(a_err_orphan), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Orphan from an idle arbiter
        @(negedge clk);
        a_mem_resp_valid = 1'b1;
        #1;
        check("idle_orphan_resp", 64'(a_resp_valid), 64'b00);
        check("idle_orphan_pre", 64'(a_err_orphan), 64'd0);
        @(negedge clk);
        a_mem_resp_valid = 1'b0;
        #1;
        check("idle_orphan_set", 64'(a_err_orphan), 64'd1);
        check("idle_orphan_cnt", 64'(a_outstanding), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-requester arbiter between the core's memory ports (instruction fetch, data, HTIF mem_req) and a single shared memory port. It replaces the fixed one-requester MemPortIo link with a generalised width, requester count and arbitration mode. It tracks outstanding requests in an in-order tag FIFO so every memory response is routed back to the port that issued it. It sits between the datapath/HTIF and the memory model or bus bridge.

## Interface
- NPORTS, 2: number of requesters, 1..8
- AW, 32: address width
- DW, 32: data width
- DEPTH, 4: maximum outstanding requests (tag FIFO depth), power of two, ≥ 2
- RR, 1: arbitration mode; 1 = round-robin, 0 = fixed priority (lowest index wins)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NPORTS  per-port request valid
- req_ready  out  NPORTS  per-port request accepted
- req_addr  in  NPORTS×AW  per-port address
- req_data  in  NPORTS×DW  per-port write data
- req_fcn  in  NPORTS×1  per-port function: 0 = M_XRD, 1 = M_XWR
- req_typ  in  NPORTS×3  per-port memory type (MT_*)
- resp_valid  out  NPORTS  per-port response valid
- resp_data  out  DW  response data, broadcast to all ports
- mem_req_valid  out  1  shared request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr / mem_req_data / mem_req_fcn / mem_req_typ  out  AW/DW/1/3  muxed request fields
- mem_resp_valid  in  1  memory response valid; exactly one per accepted request, in order
- mem_resp_data  in  DW  memory response data
- outstanding  out  log2(DEPTH)+1  current tag FIFO occupancy
- err_orphan  out  1  sticky: a response arrived with no outstanding request

## Operation
- The grant is combinational over req_valid.
  - RR=1: the search starts at rr_ptr and wraps modulo NPORTS.
  - RR=0: the lowest asserted index wins.
- mem_req_valid = |req_valid && !full. The mem_req_* fields are muxed from the granted port. When mem_req_valid is 0, the fields are don't-care.
- req_ready[g] = mem_req_valid && mem_req_ready for the granted port g. All other req_ready bits are 0.
- Handshake: a transfer occurs when mem_req_valid && mem_req_ready. On a transfer:
  - g is pushed into the tag FIFO.
  - If RR=1, rr_ptr ← (g+1) mod NPORTS.
- rr_ptr does not move without a transfer, so a stalled grant stays stable while mem_req_ready is low.
- full = (count == DEPTH). While full, no request is issued, even if a response pops in the same cycle (no bypass).
- Response routing:
  - When mem_resp_valid && !empty: resp_valid[head] = 1, resp_data = mem_resp_data, and the head is popped.
  - A response arriving while empty is dropped: no resp_valid, and err_orphan is set to 1 until reset.
- Push and pop in the same cycle leave count unchanged, and both pointers advance.
- Writes also consume a tag and receive a response; resp_data is don't-care for writes.
- Requesters must hold their request fields stable while req_valid=1 && req_ready=0.

## Timing
- Request path: zero-cycle combinational pass-through from req_* to mem_req_*, and from mem_req_ready to req_ready.
- Response path: zero-cycle combinational routing of mem_resp_* to resp_*; the tag pop takes effect at the next clk edge.
- Reset values: rr_ptr=0, count=0, head=tail=0, err_orphan=0. As a result, outstanding=0, mem_req_valid=0 and all resp_valid=0 for the duration of reset.
- Reset asserted mid-operation: all tags are discarded immediately (asynchronous). Any response the memory returns afterwards for pre-reset requests is an orphan and sets err_orphan.
- Throughput: one request per cycle while not full; one response per cycle.

## Structure
- Shared package mem_pkg:
  - M_XRD/M_XWR constants
  - MT_X, MT_B, MT_H, MT_W, MT_BU, MT_HU type codes
  - a clog2-based port-index width helper
- Sub-module tag_fifo (parameters WIDTH, DEPTH): synchronous FIFO with push/pop, full/empty and count outputs, asynchronous reset. The arbiter logic stays in mem_port_arbiter.

## Test plan
- NPORTS=2, RR=1, mem_req_ready=1 tied high, both ports requesting continuously:
  - grants alternate 0,1,0,1.
  - responses returned 2 cycles later arrive on resp_valid in that same order.
- RR=0, ports 0 and 2 of 3 requesting:
  - port 0 is granted every cycle; port 2 sees req_ready=0 until port 0 drops req_valid.
- DEPTH=4, memory never responds:
  - exactly 4 transfers, then outstanding=4 and mem_req_valid=0.
  - one response restores issue on the following cycle, not the same cycle.
- mem_req_ready held low for 3 cycles with ports 0 and 1 valid:
  - the grant stays on port 0 and the fields stay stable.
  - rr_ptr is unchanged until the transfer.
- mem_resp_valid=1 with FIFO empty:
  - no resp_valid is asserted.
  - err_orphan=1 and stays set.
  - reset clears it to 0.
- Two requests outstanding, then reset pulsed asynchronously between clock edges:
  - outstanding=0 immediately.
  - a late response sets err_orphan.
